apb_mem_ctrl: RTL

APB_MEM_CTRL -- requirements
Module: apb_mem_ctrl

---
 rtl/apb_mem_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/apb_mem_ctrl.sv
// APB slave bridging single transfers onto a pulsed memory request port,
// with alignment/range checking and a bounded wait for read data.
module apb_mem_ctrl #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 64,
   parameter int unsigned MEM_BYTES  = 65536,
   parameter int unsigned RD_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            psel,
   input  logic            penable,
   input  logic            pwrite,
   input  logic [AW-1:0]   paddr,
   input  logic [DW-1:0]   pwdata,
   input  logic [DW/8-1:0] pstrb,
   output logic            pready,
   output logic [DW-1:0]   prdata,
   output logic            pslverr,
   output logic            mem_req,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_we,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb,
   input  logic [DW-1:0]   mem_rdata,
   input  logic            mem_rvalid
);

   localparam int unsigned OFFW    = $clog2(DW/8);
   localparam logic [AW:0] MEM_LIM = (AW+1)'(MEM_BYTES);
   localparam logic [7:0]  TMO     = 8'(RD_TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

   state_t          state, state_nx;
   logic [7:0]      wait_cnt, wait_cnt_nx;
   logic            access, addr_err;
   logic            pready_nx, pslverr_nx, mem_req_nx, mem_we_nx;
   logic [DW-1:0]   prdata_nx, mem_wdata_nx;
   logic [AW-1:0]   mem_addr_nx;
   logic [DW/8-1:0] mem_wstrb_nx;

   always_comb begin
      access   = psel & penable & ~pready;
      addr_err = (paddr[OFFW-1:0] != '0) || ({1'b0, paddr} >= MEM_LIM);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (access) state_nx = addr_err ? RESP : ISSUE;
         ISSUE:   state_nx = mem_we ? RESP : RD_WAIT;
         RD_WAIT: if (mem_rvalid || wait_cnt == TMO) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead from the next state so that every
   // port comes straight from a flop.
   always_comb begin
      pready_nx    = (state_nx == RESP);
      mem_req_nx   = (state_nx == ISSUE);
      pslverr_nx   = 1'b0;
      prdata_nx    = prdata;
      mem_addr_nx  = mem_addr;
      mem_we_nx    = mem_we;
      mem_wdata_nx = mem_wdata;
      mem_wstrb_nx = mem_wstrb;
      wait_cnt_nx  = '0;
      if (state == IDLE && state_nx == ISSUE) begin
         mem_addr_nx  = paddr;
         mem_we_nx    = pwrite;
         mem_wdata_nx = pwdata;
         mem_wstrb_nx = pstrb;
      end
      if (state == RD_WAIT && state_nx == RD_WAIT)
         wait_cnt_nx = wait_cnt + 8'd1;
      if (state_nx == RESP) begin
         // Data wins over a simultaneous timeout.
         if (state == RD_WAIT && mem_rvalid) begin
            prdata_nx = mem_rdata;
         end else begin
            prdata_nx  = '0;
            pslverr_nx = (state != ISSUE);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         pready    <= 1'b0;
         prdata    <= '0;
         pslverr   <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         wait_cnt  <= wait_cnt_nx;
         pready    <= pready_nx;
         prdata    <= prdata_nx;
         pslverr   <= pslverr_nx;
         mem_req   <= mem_req_nx;
         mem_addr  <= mem_addr_nx;
         mem_we    <= mem_we_nx;
         mem_wdata <= mem_wdata_nx;
         mem_wstrb <= mem_wstrb_nx;
      end
   end

endmodule
